// File: rtl/puf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | puf_pkg                                                               |
// | FSM state encoding and Galois LFSR polynomials for br_puf_ctrl.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DECIDE = 3'd4,
        ST_DONE   = 3'd5
    } puf_state_e;

    localparam int c_lfsr_max_w = 128;

    // Right-shift Galois masks: bit (k-1) set for every x^k term, k >= 1.
    function automatic logic [c_lfsr_max_w-1:0] lfsr_taps(input int cw);
        logic [c_lfsr_max_w-1:0] t;
        t = '0;
        case (cw)
            8:       t[7:0]  = 8'hB8;
            16:      t[15:0] = 16'hB400;
            32:      t[31:0] = 32'h8020_0003;
            64:      t[63:0] = 64'hD800_0000_0000_0000;
            128:     t       = {1'b1, 98'd0, 29'h1400_0002};
            default: t       = '0;
        endcase
        return t;
    endfunction

    function automatic logic [c_lfsr_max_w-1:0] lfsr_step(input logic [c_lfsr_max_w-1:0] s,
                                                         input int cw);
        return (s >> 1) ^ (s[0] ? lfsr_taps(cw) : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | puf_sync2                                                             |
// | Two-flop synchronizer, synchronous active-low reset.                  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module puf_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/br_puf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_puf_ctrl                                                           |
// | Bistable-ring PUF controller: per-bit reset/settle/majority sampling. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module br_puf_ctrl
    import puf_pkg::*;
#(
    parameter int CW         = 128,
    parameter int RW         = 32,
    parameter int NS         = 5,
    parameter int RST_CYC    = 8,
    parameter int SETTLE_CYC = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CW-1:0]             seed,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [RW-1:0]             resp,
    output logic [$clog2(RW+1)-1:0]   unstable_cnt,
    output logic                      ring_reset,
    output logic [CW-1:0]             ring_c,
    input  logic                      ring_out
);

    localparam int c_cnt_max = (RST_CYC > SETTLE_CYC) ?
                               ((RST_CYC > NS) ? RST_CYC : NS) :
                               ((SETTLE_CYC > NS) ? SETTLE_CYC : NS);
    localparam int c_cnt_w  = $clog2(c_cnt_max + 1);
    localparam int c_ones_w = $clog2(NS + 1);
    localparam int c_idx_w  = (RW > 1) ? $clog2(RW) : 1;
    localparam int c_ucnt_w = $clog2(RW + 1);

    localparam logic [c_cnt_w-1:0]  c_rst_last    = c_cnt_w'(RST_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_ns_last     = c_cnt_w'(NS - 1);
    localparam logic [c_ones_w-1:0] c_ns_half     = c_ones_w'(NS / 2);
    localparam logic [c_ones_w-1:0] c_ns_all      = c_ones_w'(NS);
    localparam logic [c_idx_w-1:0]  c_idx_last    = c_idx_w'(RW - 1);

    if (!(CW == 8 || CW == 16 || CW == 32 || CW == 64 || CW == 128)) begin : g_bad_cw
        $error("br_puf_ctrl: CW must be 8, 16, 32, 64 or 128");
    end
    if (RW < 1) begin : g_bad_rw
        $error("br_puf_ctrl: RW must be at least 1");
    end
    if (NS < 1 || (NS % 2) == 0) begin : g_bad_ns
        $error("br_puf_ctrl: NS must be odd and at least 1");
    end
    if (RST_CYC < 1) begin : g_bad_rst
        $error("br_puf_ctrl: RST_CYC must be at least 1");
    end
    if (SETTLE_CYC < 2) begin : g_bad_settle
        $error("br_puf_ctrl: SETTLE_CYC must be at least 2");
    end

    puf_state_e            r_state;
    puf_state_e            w_state_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_ones_w-1:0]   r_ones;
    logic [c_idx_w-1:0]    r_idx;
    logic [CW-1:0]         r_lfsr;
    logic [CW-1:0]         r_chal;
    logic [RW-1:0]         r_resp;
    logic [c_ucnt_w-1:0]   r_ucnt;

    logic                  w_ring_sync;
    logic [CW-1:0]         w_seed_nz;
    logic [127:0]          w_lfsr_wide;
    logic [CW-1:0]         w_lfsr_next;
    logic                  w_bit;
    logic                  w_unstable;
    logic                  w_last_bit;

    puf_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ring_out),
        .q       (w_ring_sync)
    );

    assign w_seed_nz   = (seed == '0) ? CW'(1) : seed;
    assign w_lfsr_wide = lfsr_step(128'(r_lfsr), CW);
    assign w_lfsr_next = w_lfsr_wide[CW-1:0];
    assign w_bit       = (r_ones > c_ns_half);
    assign w_unstable  = (r_ones != '0) && (r_ones != c_ns_all);
    assign w_last_bit  = (r_idx == c_idx_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ones  <= '0;
            r_idx   <= '0;
            r_lfsr  <= '0;
            r_chal  <= '0;
            r_resp  <= '0;
            r_ucnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_DONE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_lfsr <= w_seed_nz;
                        r_chal <= w_seed_nz;
                        r_idx  <= '0;
                        r_ones <= '0;
                        r_resp <= '0;
                        r_ucnt <= '0;
                    end
                end
                ST_SAMPLE: r_ones <= r_ones + c_ones_w'(w_ring_sync);
                ST_DECIDE: begin
                    r_resp <= r_resp | (RW'(w_bit) << r_idx);
                    if (w_unstable) begin
                        r_ucnt <= r_ucnt + 1'b1;
                    end
                    r_lfsr <= w_lfsr_next;
                    r_ones <= '0;
                    // The challenge register only moves on the way into RST.
                    if (!w_last_bit) begin
                        r_idx  <= r_idx + 1'b1;
                        r_chal <= w_lfsr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_next = ST_RST;
            ST_RST:    if (r_cnt == c_rst_last) w_state_next = ST_SETTLE;
            ST_SETTLE: if (r_cnt == c_settle_last) w_state_next = ST_SAMPLE;
            ST_SAMPLE: if (r_cnt == c_ns_last) w_state_next = ST_DECIDE;
            ST_DECIDE: w_state_next = w_last_bit ? ST_DONE : ST_RST;
            ST_DONE:   if (rsp_ready) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // DECIDE re-arms the ring reset so the challenge never changes under a free-running ring.
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ring_reset = 1'b1;
        ring_c     = '0;
        case (r_state)
            ST_IDLE:   req_ready = reset_n;
            ST_RST:    ring_c = r_chal;
            ST_SETTLE: begin
                ring_reset = 1'b0;
                ring_c     = r_chal;
            end
            ST_SAMPLE: begin
                ring_reset = 1'b0;
                ring_c     = r_chal;
            end
            ST_DECIDE: ring_c = r_chal;
            ST_DONE: begin
                rsp_valid = 1'b1;
                ring_c    = r_chal;
            end
            default: ;
        endcase
    end

    assign resp         = r_resp;
    assign unstable_cnt = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_br_puf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_br_puf_ctrl                                                        |
// | Self-checking bench: vector table, scoreboard and corner sequences.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_br_puf_ctrl;

    localparam int CW         = 128;
    localparam int RW         = 4;
    localparam int NS         = 3;
    localparam int RST_CYC    = 2;
    localparam int SETTLE_CYC = 4;
    localparam int PER_BIT    = RST_CYC + SETTLE_CYC + NS + 1;
    localparam int LAT        = RW * PER_BIT;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b1;
    logic          ring_out = 1'b0;
    logic [CW-1:0] seed = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          ring_reset;
    logic [CW-1:0] ring_c;
    logic [RW-1:0] resp;
    logic [2:0]    unstable_cnt;

    int cyc = 0;
    int acc_cyc = 0;
    int ring_mode = 1;
    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_rsp = 0;
    int ring_viol = 0;
    bit chk_ring_en = 1'b1;
    logic [RW-1:0] cur_exp_resp = '0;
    logic [2:0]    cur_exp_ucnt = '0;

    typedef struct {
        logic [RW-1:0] resp;
        logic [2:0]    ucnt;
        int            acc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            mode;
        logic [CW-1:0] seed;
        logic [RW-1:0] resp;
        logic [2:0]    ucnt;
    } vec_t;

    br_puf_ctrl #(
        .CW(CW), .RW(RW), .NS(NS), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .seed         (seed),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .resp         (resp),
        .unstable_cnt (unstable_cnt),
        .ring_reset   (ring_reset),
        .ring_c       (ring_c),
        .ring_out     (ring_out)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ring behaviour as a function of cycles since acceptance; samples see rel-2.
    function automatic logic ring_pat(input int mode, input int rel);
        logic [3:0] pat;
        pat = 4'b0101;
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        if (rel < 0 || rel >= LAT) return 1'b0;
        case (mode)
            2:       return (rel % 2) == 1;
            3:       return (rel % 2) == 0;
            4:       return pat[rel / PER_BIT];
            5:       return ((rel % PER_BIT) == 4) || ((rel / PER_BIT) == 2);
            6:       return ((rel % PER_BIT) != 6) && ((rel / PER_BIT) != 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [127:0] gstep(input logic [127:0] s);
        logic [127:0] m;
        m = '0;
        m[127] = 1'b1;
        m[28]  = 1'b1;
        m[26]  = 1'b1;
        m[1]   = 1'b1;
        return s[0] ? ((s >> 1) ^ m) : (s >> 1);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        ring_out = ring_pat(ring_mode, cyc - acc_cyc);
    end

    // Scoreboard: push on handshake, pop on rising rsp_valid.
    initial begin
        logic          prev_v;
        logic          prev_rr;
        logic [CW-1:0] prev_c;
        exp_t          e;
        prev_v  = 1'b0;
        prev_rr = 1'b1;
        prev_c  = '0;
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                acc_cyc = cyc + 1;
                n_acc++;
                sb.push_back('{cur_exp_resp, cur_exp_ucnt, cyc + 1});
            end
            if (rsp_valid && !prev_v) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid with resp %0h, required no response", resp);
                end else begin
                    e = sb.pop_front();
                    check("resp", resp, e.resp);
                    check("unstable_cnt", unstable_cnt, e.ucnt);
                    check("rsp_latency", cyc - e.acc, LAT);
                end
            end
            if (chk_ring_en && (ring_c !== prev_c) && !(prev_rr && ring_reset)) ring_viol++;
            prev_v  = rsp_valid;
            prev_rr = ring_reset;
            prev_c  = ring_c;
        end
    end

    task automatic do_request(input logic [CW-1:0] s);
        int t;
        t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_wait: got req_ready 0, required 1 within 200 cycles");
        end
        seed      = s;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string name);
        int t;
        t = 0;
        while (n_rsp < target && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (n_rsp < target) begin
            errors++;
            $display("FAIL %s: got %0d responses, required %0d", name, n_rsp, target);
        end
    endtask

    initial begin
        vec_t          vt[7];
        logic [127:0]  exp_c;
        logic [RW-1:0] held;
        int            bad;
        int            acc0;
        int            rsp0;
        int            t;

        vt[0] = '{1, 128'h1,    4'b1111, 3'd0};
        vt[1] = '{2, 128'h9,    4'b0000, 3'd4};
        vt[2] = '{3, 128'hA5,   4'b1111, 3'd4};
        vt[3] = '{0, 128'h1234, 4'b0000, 3'd0};
        vt[4] = '{4, 128'h77,   4'b0101, 3'd0};
        vt[5] = '{5, 128'h3,    4'b0100, 3'd3};
        vt[6] = '{6, 128'h81,   4'b1101, 3'd3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_resp", resp, 0);
        check("rst_ucnt", unstable_cnt, 0);
        check("rst_ring_c", ring_c, 0);
        check("rst_ring_reset", ring_reset, 1);
        reset_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset", req_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            ring_mode    = vt[i].mode;
            cur_exp_resp = vt[i].resp;
            cur_exp_ucnt = vt[i].ucnt;
            rsp0 = n_rsp;
            do_request(vt[i].seed);
            wait_rsp(rsp0 + 1, "vec_rsp");
        end

        // Zero seed, challenge sequence and settle-phase ring reset.
        ring_mode = 1; cur_exp_resp = 4'b1111; cur_exp_ucnt = 3'd0;
        rsp0 = n_rsp;
        do_request('0);
        exp_c = 128'd1;
        for (int k = 0; k < LAT; k++) begin
            if (k % PER_BIT == 0) begin
                check("ring_c_chal", ring_c, exp_c);
                check("ring_reset_rst", ring_reset, 1);
                exp_c = gstep(exp_c);
            end
            if (k % PER_BIT == RST_CYC) check("ring_reset_settle", ring_reset, 0);
            @(posedge clk);
            #1;
        end
        wait_rsp(rsp0 + 1, "lfsr_rsp");

        // Consumer stalls in DONE; requests during the stall are ignored.
        rsp_ready = 1'b0; ring_mode = 3; cur_exp_resp = 4'b1111; cur_exp_ucnt = 3'd4;
        rsp0 = n_rsp;
        do_request(128'h55);
        wait_rsp(rsp0 + 1, "stall_rsp");
        acc0 = n_acc;
        held = resp;
        bad  = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = (k % 3 == 0);
            if (resp !== held || rsp_valid !== 1'b1 || req_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("done_hold_bad_cycles", bad, 0);
        check("done_req_ignored", n_acc - acc0, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_done_req_ready", req_ready, 1);
        check("idle_after_done_rsp_valid", rsp_valid, 0);
        check("idle_resp_retained", resp, 4'b1111);
        check("idle_ucnt_retained", unstable_cnt, 4);

        // Busy requests are ignored; acceptance clears the previous result.
        ring_mode = 1; cur_exp_resp = 4'b1111; cur_exp_ucnt = 3'd0;
        acc0 = n_acc;
        rsp0 = n_rsp;
        do_request(128'h3);
        check("accept_clears_resp", resp, 0);
        check("accept_clears_ucnt", unstable_cnt, 0);
        for (int k = 0; k < 20; k++) begin
            req_valid = (k >= 5 && k <= 12);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_rsp(rsp0 + 1, "busy_rsp");
        check("busy_req_ignored", n_acc - acc0, 1);

        // Back-to-back with rsp_ready tied high.
        acc0 = n_acc;
        rsp0 = n_rsp;
        seed = 128'hBEEF;
        req_valid = 1'b1;
        t = 0;
        while ((n_acc - acc0) < 3 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = 1'b0;
        wait_rsp(rsp0 + 3, "b2b_rsp");
        check("b2b_accepts", n_acc - acc0, 3);
        check("b2b_responses", n_rsp - rsp0, 3);

        // Reset pulse at cycle 15 of a request.
        ring_mode = 1; cur_exp_resp = 4'b1111; cur_exp_ucnt = 3'd0;
        rsp0 = n_rsp;
        do_request(128'h7);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        chk_ring_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_resp", resp, 0);
        check("abort_ucnt", unstable_cnt, 0);
        check("abort_ring_c", ring_c, 0);
        check("abort_ring_reset", ring_reset, 1);
        reset_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_req_ready_release", req_ready, 1);
        chk_ring_en = 1'b1;
        bad = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) bad++;
        end
        check("abort_no_rsp_valid", bad, 0);
        check("abort_no_response", n_rsp - rsp0, 0);
        ring_mode = 4; cur_exp_resp = 4'b0101; cur_exp_ucnt = 3'd0;
        do_request(128'h11);
        wait_rsp(rsp0 + 1, "post_abort_rsp");

        repeat (3) @(posedge clk);
        #1;
        check("ring_c_change_under_run", ring_viol, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/br_puf_ctrl.md
BR_PUF_CTRL -- requirements
Module: br_puf_ctrl

Interface
REQ-001 SHALL have parameter CW, default 128: challenge width driven to the bistable ring; legal values are 8, 16, 32, 64 and 128.
REQ-002 SHALL have parameter RW, default 32: response bits produced per request.
REQ-003 SHALL have parameter NS, default 5: samples taken per response bit; must be odd and at least 1.
REQ-004 SHALL have parameter RST_CYC, default 8: ring-reset hold cycles per bit; must be at least 1.
REQ-005 SHALL have parameter SETTLE_CYC, default 64: settle cycles after reset release; must be at least 2.
REQ-006 SHALL have port CLK, input, 1: the single clock.
REQ-007 SHALL have port RESET_N, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port REQ_VALID, input, 1: request strobe.
REQ-009 SHALL have port REQ_READY, output, 1: controller idle and able to accept a request.
REQ-010 SHALL have port SEED, input, CW: initial challenge, captured on request acceptance.
REQ-011 SHALL have port RSP_VALID, output, 1: response available.
REQ-012 SHALL have port RSP_READY, input, 1: consumer accepts the response.
REQ-013 SHALL have port RESP, output, RW: response word.
REQ-014 SHALL have port UNSTABLE_CNT, output, clog2(RW+1): number of non-unanimous bits in the last response.
REQ-015 SHALL have port RING_RESET, output, 1: drives the ring's RESET pin; active-high.
REQ-016 SHALL have port RING_C, output, CW: drives the ring's challenge pins.
REQ-017 SHALL have port RING_OUT, input, 1: ring output; asynchronous to CLK.

Function
REQ-018 SHALL pass RING_OUT through a 2-flop synchronizer before any use.
REQ-019 SHALL implement the FSM states IDLE, RST, SETTLE, SAMPLE, DECIDE and DONE.
REQ-020 IDLE: REQ_READY=1, RING_RESET=1, RING_C=0.
REQ-021 IDLE: on REQ_VALID&&REQ_READY, SHALL load the LFSR with SEED (with 1 substituted if SEED==0), clear bit index, RESP and UNSTABLE_CNT, and enter RST.
REQ-022 RST: SHALL hold RING_RESET=1 and RING_C=LFSR for RST_CYC cycles, then enter SETTLE.
REQ-023 SETTLE: SHALL hold RING_RESET=0 and RING_C unchanged for SETTLE_CYC cycles, then enter SAMPLE.
REQ-024 SAMPLE: SHALL capture one synchronized sample per cycle for NS cycles and count the ones.
REQ-025 DECIDE (1 cycle): SHALL set RESP[idx] = (ones > NS/2).
REQ-026 DECIDE: if ones is neither 0 nor NS, SHALL increment UNSTABLE_CNT.
REQ-027 DECIDE: SHALL advance the LFSR by one Galois step.
REQ-028 DECIDE: if idx==RW-1 SHALL enter DONE, otherwise increment idx and enter RST.
REQ-029 RING_C SHALL change only on entry to RST and SHALL never change while RING_RESET=0.
REQ-030 Per-bit time SHALL be exactly RST_CYC+SETTLE_CYC+NS+1 cycles.
REQ-031 RSP_VALID SHALL rise exactly RW*(RST_CYC+SETTLE_CYC+NS+1) cycles after the acceptance edge.
REQ-032 DONE: RSP_VALID=1, RING_RESET=1; RESP and UNSTABLE_CNT SHALL be held stable until RSP_READY.
REQ-033 DONE: on RSP_READY, SHALL enter IDLE on the next edge; REQ_READY=1 in that cycle.
REQ-034 SHALL ignore REQ_VALID outside IDLE.
REQ-035 SHALL accept RSP_READY asserted in advance, so that a DONE state lasting one cycle is legal.
REQ-036 After DONE, RESP and UNSTABLE_CNT SHALL retain their values in IDLE until the next acceptance.

Reset
REQ-037 While RESET_N=0 at a CLK edge: state=IDLE, REQ_READY=0, RSP_VALID=0, RESP=0, UNSTABLE_CNT=0, RING_C=0, RING_RESET=1, counters, LFSR and synchronizer all cleared.
REQ-038 Reset asserted mid-operation SHALL abort the operation with no response issued.
REQ-039 REQ_READY SHALL be 1 in the first cycle after RESET_N returns high.

Structure
REQ-040 Package puf_pkg SHALL hold the FSM state enum and the LFSR tap constants for each legal CW, selected by a function of CW; CW=128 uses x^128+x^29+x^27+x^2+1 and CW=8 uses x^8+x^6+x^5+x^4+1.
REQ-041 SHALL contain one sub-module, puf_sync2: a parameter-free 2-flop synchronizer with synchronous active-low reset.
REQ-042 The ring macro SHALL be instantiated outside this block and SHALL NOT be instantiated inside it.
REQ-043 Illegal parameter values SHALL raise an elaboration-time error.

Verification (RW=4, NS=3, RST_CYC=2, SETTLE_CYC=4, CW=128: 10 cycles per bit)
REQ-044 Bench SHALL cover: RING_OUT tied 1, SEED=1 -> RSP_VALID exactly 40 cycles after acceptance, RESP=4'b1111, UNSTABLE_CNT=0.
REQ-045 Bench SHALL cover: model toggling RING_OUT every sample cycle -> each bit decided by 2-of-3, UNSTABLE_CNT=4.
REQ-046 Bench SHALL cover: SEED=0 -> first RING_C=1; successive RING_C values match the package Galois LFSR reference; RING_C never changes while RING_RESET=0.
REQ-047 Bench SHALL cover: RSP_READY held low 20 cycles in DONE -> RESP stable, REQ_VALID pulses ignored; after RSP_READY, REQ_READY=1 the next cycle.
REQ-048 Bench SHALL cover: RESET_N low for one cycle at cycle 15 of a request -> all outputs at reset values, no RSP_VALID, a new request then completes normally.
REQ-049 Bench SHALL cover: REQ_VALID asserted while busy -> no effect; back-to-back requests with RSP_READY tied high -> one response per request, none lost.
